// File: rtl/tt_pin_pkg.sv
// ---------------------------------------------------------------------------
// tt_pin_pkg
// Shared definitions for the Tiny Tapeout pin-bus host and the project-side
// decoder: FSM state encoding, uio_in bit positions of the strobe/write/phase
// lines, and the default uio_out bit that carries the project's ack.
// No ports (package).
// ---------------------------------------------------------------------------
package tt_pin_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    DATA     = 3'd2,
    WAIT_ACK = 3'd3,
    RESP     = 3'd4,
    RELEASE  = 3'd5
  } state_t;

  localparam int UIO_STB         = 0;
  localparam int UIO_WE          = 1;
  localparam int UIO_PHASE       = 2;
  localparam int DEFAULT_ACK_BIT = 7;

  // Builds the uio_in control byte; unused upper bits are always zero.
  function automatic logic [7:0] uioWord(input logic stb, input logic we, input logic phase);
    logic [7:0] word;
    word            = 8'h00;
    word[UIO_STB]   = stb;
    word[UIO_WE]    = we;
    word[UIO_PHASE] = phase;
    return word;
  endfunction

endpackage

// File: rtl/tt_pin_host_if.sv
// ---------------------------------------------------------------------------
// tt_pin_host_if
// Bundles the command/response handshake and the Tiny Tapeout pin bus seen
// by the host.
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command in
//   rsp_valid/rsp_rdata/rsp_err                      : response out
//   pin_ui/pin_uio                                   : host -> project ui_in/uio_in
//   pin_uo/pin_uio_o/pin_uio_oe                      : project uo_out/uio_out/uio_oe -> host
// Modport slave is the host block itself; master is its environment
// (command issuer plus user project).
// ---------------------------------------------------------------------------
interface tt_pin_host_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;

  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  logic [7:0] pin_ui;
  logic [7:0] pin_uio;
  logic [7:0] pin_uo;
  logic [7:0] pin_uio_o;
  logic [7:0] pin_uio_oe;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  pin_ui, pin_uio,
    output pin_uo, pin_uio_o, pin_uio_oe
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output pin_ui, pin_uio,
    input  pin_uo, pin_uio_o, pin_uio_oe
  );

endinterface

// File: rtl/tt_pin_host.sv
// ---------------------------------------------------------------------------
// tt_pin_host
// Host-side driver for the Tiny Tapeout user-project pin bus. Each accepted
// command becomes an address strobe, a data strobe, a wait for the project's
// ack (captured read data from uo_out), a one-cycle response pulse, and a
// four-phase release wait for ack to drop.
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in WAIT_ACK or RELEASE (2..65535)
//   ACK_BIT        : uio_out bit carrying the ack; its uio_oe bit must be 1
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : tt_pin_host_if.slave (command, response and pin signals)
// ---------------------------------------------------------------------------
module tt_pin_host
  import tt_pin_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ACK_BIT        = DEFAULT_ACK_BIT
) (
  input  logic         clk,
  input  logic         rst,
  tt_pin_host_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_nextState;
  logic             r_write;
  logic [7:0]       r_wdata;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_pinUi;
  logic [7:0]       r_pinUio;
  logic             r_rspValid;
  logic [7:0]       r_rspRdata;
  logic             r_rspErr;

  logic             w_handshake;
  logic             w_ack;
  logic             w_badOe;
  logic             w_timeout;
  logic [7:0]       w_pinUi;
  logic [7:0]       w_pinUio;
  logic             w_rspValid;
  logic [7:0]       w_rspRdata;
  logic             w_rspErr;
  logic             w_unused;

  assign w_handshake = bus.cmd_valid & (r_state == IDLE);
  // An ack only counts when the project actually drives the pin; a high
  // value on an undriven pin is reported as an error instead.
  assign w_ack       = bus.pin_uio_o[ACK_BIT] & bus.pin_uio_oe[ACK_BIT];
  assign w_badOe     = bus.pin_uio_o[ACK_BIT] & ~bus.pin_uio_oe[ACK_BIT];
  assign w_timeout   = (r_count >= CNT_LAST);
  assign w_unused    = ^{bus.pin_uio_o, bus.pin_uio_oe};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic. Ack has priority over the bad-oe error and the timeout.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_handshake) w_nextState = ADDR;
      ADDR:     w_nextState = DATA;
      DATA:     w_nextState = WAIT_ACK;
      WAIT_ACK: if (w_ack || w_badOe || w_timeout) w_nextState = RESP;
      RESP:     w_nextState = RELEASE;
      RELEASE:  if (!w_ack || w_timeout) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Output logic: computes the value every registered output takes in the
  // state being entered, so pins and response change together with the state.
  // The address goes straight from the command bus into the pin register at
  // the handshake edge, so it needs no separate latch.
  always_comb begin
    w_pinUi    = 8'h00;
    w_pinUio   = 8'h00;
    w_rspValid = 1'b0;
    w_rspRdata = r_rspRdata;
    w_rspErr   = r_rspErr;
    case (w_nextState)
      ADDR: begin
        w_pinUi  = bus.cmd_addr;
        w_pinUio = uioWord(1'b1, bus.cmd_write, 1'b0);
      end
      DATA: begin
        w_pinUi  = r_write ? r_wdata : 8'h00;
        w_pinUio = uioWord(1'b1, r_write, 1'b1);
      end
      WAIT_ACK: begin
        w_pinUi  = r_pinUi;
        w_pinUio = uioWord(1'b0, r_write, 1'b1);
      end
      RESP: begin
        w_rspValid = 1'b1;
        w_rspErr   = ~w_ack;
        w_rspRdata = (w_ack && !r_write) ? bus.pin_uo : 8'h00;
      end
      default: begin
        w_pinUi  = 8'h00;
        w_pinUio = 8'h00;
      end
    endcase
  end

  // Output, command-latch and counter registers. The counter runs only while
  // waiting on the project and is cleared everywhere else, so each wait phase
  // starts from zero; it saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_wdata    <= 8'h00;
      r_count    <= '0;
      r_pinUi    <= 8'h00;
      r_pinUio   <= 8'h00;
      r_rspValid <= 1'b0;
      r_rspRdata <= 8'h00;
      r_rspErr   <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_write <= bus.cmd_write;
        r_wdata <= bus.cmd_wdata;
      end
      if (r_state == WAIT_ACK || r_state == RELEASE) begin
        if (r_count != CNT_SAT) r_count <= r_count + 1'b1;
      end else begin
        r_count <= '0;
      end
      r_pinUi    <= w_pinUi;
      r_pinUio   <= w_pinUio;
      r_rspValid <= w_rspValid;
      r_rspRdata <= w_rspRdata;
      r_rspErr   <= w_rspErr;
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_rdata = r_rspRdata;
  assign bus.rsp_err   = r_rspErr;
  assign bus.pin_ui    = r_pinUi;
  assign bus.pin_uio   = r_pinUio;

endmodule

// File: tb/tb_tt_pin_host.sv
// ---------------------------------------------------------------------------
// tb_tt_pin_host
// Directed bench for tt_pin_host with TIMEOUT_CYCLES=8. Expected responses
// are queued when a command is issued and popped when rsp_valid appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tt_pin_host;
  import tt_pin_pkg::*;

  localparam int TIMEOUT    = 8;
  localparam int WAIT_LIMIT = 40;

  logic       clk;
  logic       rst;
  int         checkCount = 0;
  int         passCount  = 0;
  int         rspPulses  = 0;
  logic [8:0] expQ[$];

  tt_pin_host_if bus ();

  tt_pin_host #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .ACK_BIT       (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every response pulse so dropped or duplicated responses show up.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) rspPulses <= rspPulses + 1;
  end

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Offers a command, waits (bounded) for acceptance, returns in ADDR.
  task automatic applyStimulus(input logic write, input logic [7:0] addr, input logic [7:0] wdata);
    int waited = 0;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cmd_ready before handshake", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic popCheck(input string tag);
    logic [8:0] e;
    checkOutput({tag, " queue"}, expQ.size() > 0, 1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, " rdata"}, bus.rsp_rdata, e[8:1]);
      checkOutput({tag, " err"}, bus.rsp_err, e[0]);
    end
  endtask

  task automatic waitRsp(input string tag, output int cycles);
    cycles = 0;
    while (bus.rsp_valid !== 1'b1 && cycles < WAIT_LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " rsp_valid"}, bus.rsp_valid, 1);
    if (bus.rsp_valid === 1'b1) popCheck(tag);
  endtask

  // Complete command with an earliest-possible ack and prompt release.
  task automatic doCmd(input string tag, input logic write, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] uoVal);
    int cyc;
    applyStimulus(write, addr, wdata);
    expQ.push_back({write ? 8'h00 : uoVal, 1'b0});
    @(negedge clk);
    bus.pin_uo     = uoVal;
    bus.pin_uio_o  = 8'h80;
    bus.pin_uio_oe = 8'h80;
    waitRsp(tag, cyc);
    checkOutput({tag, " latency"}, cyc, 2);
    bus.pin_uio_o = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput({tag, " ready again"}, bus.cmd_ready, 1);
  endtask

  initial begin
    int         cyc;
    int         pulsesBefore;
    int         hs;
    int         rsps;
    int         addrSeen;
    int         dataSeen;
    int         hsCyc[2];
    logic       changePending;
    logic [7:0] addrList[2];
    logic [7:0] dataList[2];

    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = 8'h00;
    bus.cmd_wdata  = 8'h00;
    bus.pin_uo     = 8'h00;
    bus.pin_uio_o  = 8'h00;
    bus.pin_uio_oe = 8'h80;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("reset cmd_ready", bus.cmd_ready, 1);
    checkOutput("reset rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 8'h00);
    checkOutput("reset rsp_err", bus.rsp_err, 0);
    checkOutput("reset pin_ui", bus.pin_ui, 8'h00);
    checkOutput("reset pin_uio", bus.pin_uio, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Write 0x12 <= 0xA5, ack two cycles after DATA.
    $display("[TB] write 0x12 <= 0xA5");
    applyStimulus(1'b1, 8'h12, 8'hA5);
    expQ.push_back({8'h00, 1'b0});
    checkOutput("wr addr pin_ui", bus.pin_ui, 8'h12);
    checkOutput("wr addr pin_uio", bus.pin_uio, 8'h03);
    checkOutput("wr busy cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    checkOutput("wr data pin_ui", bus.pin_ui, 8'hA5);
    checkOutput("wr data pin_uio", bus.pin_uio, 8'h07);
    @(negedge clk);
    checkOutput("wr wait pin_ui", bus.pin_ui, 8'hA5);
    checkOutput("wr wait stb/we", bus.pin_uio[1:0], 2'b10);
    @(negedge clk);
    bus.pin_uio_o = 8'h80;
    waitRsp("wr", cyc);
    checkOutput("wr ack-to-rsp", cyc, 1);
    checkOutput("wr resp pin_ui", bus.pin_ui, 8'h00);
    checkOutput("wr resp pin_uio", bus.pin_uio, 8'h00);
    bus.pin_uio_o = 8'h00;
    @(negedge clk);
    checkOutput("wr release cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    checkOutput("wr idle cmd_ready", bus.cmd_ready, 1);

    // Read 0x34 returning 0x5C, ack held high after the response.
    $display("[TB] read 0x34, ack held after response");
    @(negedge clk);
    #1 pulsesBefore = rspPulses;
    applyStimulus(1'b0, 8'h34, 8'hFF);
    expQ.push_back({8'h5C, 1'b0});
    checkOutput("rd addr pin_ui", bus.pin_ui, 8'h34);
    checkOutput("rd addr pin_uio", bus.pin_uio, 8'h01);
    @(negedge clk);
    checkOutput("rd data pin_ui", bus.pin_ui, 8'h00);
    checkOutput("rd data pin_uio", bus.pin_uio, 8'h05);
    bus.pin_uo    = 8'h5C;
    bus.pin_uio_o = 8'h80;
    waitRsp("rd", cyc);
    checkOutput("rd latency", cyc, 2);
    bus.pin_uo = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rd ack held cmd_ready", bus.cmd_ready, 0);
    end
    bus.pin_uio_o = 8'h00;
    @(negedge clk);
    checkOutput("rd ack dropped cmd_ready", bus.cmd_ready, 1);
    checkOutput("rd rdata held", bus.rsp_rdata, 8'h5C);
    @(negedge clk);
    #1 checkOutput("rd single pulse", rspPulses - pulsesBefore, 1);

    // No ack: timeout after eight WAIT_ACK cycles.
    $display("[TB] read with no ack");
    bus.pin_uo = 8'h99;
    applyStimulus(1'b0, 8'h56, 8'h00);
    expQ.push_back({8'h00, 1'b1});
    waitRsp("timeout", cyc);
    checkOutput("timeout latency", cyc, 10);
    repeat (2) @(negedge clk);
    checkOutput("timeout back to idle", bus.cmd_ready, 1);

    // Ack bit high while not output-enabled.
    $display("[TB] write with ack pin not enabled");
    applyStimulus(1'b1, 8'h78, 8'h3C);
    expQ.push_back({8'h00, 1'b1});
    @(negedge clk);
    bus.pin_uio_o  = 8'h80;
    bus.pin_uio_oe = 8'h00;
    waitRsp("bad oe", cyc);
    checkOutput("bad oe latency", cyc, 2);
    repeat (2) @(negedge clk);
    checkOutput("bad oe back to idle", bus.cmd_ready, 1);
    bus.pin_uio_o  = 8'h00;
    bus.pin_uio_oe = 8'h80;

    // Reset during WAIT_ACK drops the transaction.
    $display("[TB] reset during WAIT_ACK");
    applyStimulus(1'b0, 8'h9A, 8'h00);
    repeat (2) @(negedge clk);
    #1 pulsesBefore = rspPulses;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst pin_uio", bus.pin_uio, 8'h00);
    checkOutput("rst pin_ui", bus.pin_ui, 8'h00);
    checkOutput("rst cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 checkOutput("rst no response", rspPulses - pulsesBefore, 0);
    doCmd("post-rst rd", 1'b0, 8'hBC, 8'h00, 8'h3D);

    // Back-to-back writes with cmd_valid held high.
    $display("[TB] back-to-back writes");
    addrList[0] = 8'h40; dataList[0] = 8'h11;
    addrList[1] = 8'h41; dataList[1] = 8'h22;
    hs = 0; rsps = 0; addrSeen = 0; dataSeen = 0;
    hsCyc[0] = 0; hsCyc[1] = 0;
    changePending = 1'b0;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = addrList[0];
    bus.cmd_wdata = dataList[0];
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (hs == 2 && rsps == 2) break;
      if (changePending) begin
        changePending = 1'b0;
        if (hs == 1) begin
          bus.cmd_addr  = addrList[1];
          bus.cmd_wdata = dataList[1];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (bus.rsp_valid === 1'b1) begin
        rsps++;
        bus.pin_uio_o = 8'h00;
        popCheck("b2b");
      end
      if (bus.pin_uio === 8'h03 && addrSeen < 2) begin
        checkOutput("b2b addr pin_ui", bus.pin_ui, addrList[addrSeen]);
        addrSeen++;
      end
      if (bus.pin_uio === 8'h07 && dataSeen < 2) begin
        checkOutput("b2b data pin_ui", bus.pin_ui, dataList[dataSeen]);
        dataSeen++;
        bus.pin_uio_o = 8'h80;
      end
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1 && hs < 2) begin
        hsCyc[hs] = c;
        hs++;
        expQ.push_back({8'h00, 1'b0});
        changePending = 1'b1;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    checkOutput("b2b handshakes", hs, 2);
    checkOutput("b2b responses", rsps, 2);
    checkOutput("b2b spacing >= 5", (hsCyc[1] - hsCyc[0]) >= 5, 1);
    repeat (3) @(negedge clk);

    #1;
    checkOutput("scoreboard empty", expQ.size(), 0);
    checkOutput("total rsp pulses", rspPulses, 7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
